// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the sum_accumulator block.
package sum_acc_pkg;

    // Default operand/sum width and burst-length field width.
    localparam int SUM_ACC_WIDTH = 32;
    localparam int SUM_ACC_CNT_W = 8;

    // Widest sum the saturate helper can produce.
    localparam int SUM_ACC_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } sum_acc_state_e;

    // All-ones pattern that the accumulator clamps to on overflow when
    // saturation is compiled in. Callers size-cast it down to WIDTH.
    function automatic logic [SUM_ACC_MAX_W-1:0] sat_ones();
        return '1;
    endfunction

endpackage

// File: rtl/acc_add_core.sv
// WIDTH-bit ripple-carry adder: one full-adder cell per bit, carry chained
// from bit 0 upward. Purely combinational.
module acc_add_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = i_cin;

    // One full-adder cell per bit; each cell feeds its carry to the next.
    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign o_sum[g]       = i_a[g] ^ i_b[g] ^ w_carry[g];
        assign w_carry[g + 1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_carry[WIDTH];

endmodule

// File: rtl/sum_accumulator.sv
// Burst accumulator: sums burst_len unsigned operands through a ripple-carry
// adder and presents one registered sum with a sticky overflow flag.
// Optional feature macro: SUM_ACC_SATURATE_EN (clamp sum to all-ones on carry).
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int WIDTH = SUM_ACC_WIDTH,
    parameter int CNT_W = SUM_ACC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_burst_len,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_sum,
    output logic             o_out_overflow,
    output logic             o_busy
);

    sum_acc_state_e   r_state;
    sum_acc_state_e   w_next;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_beat;

    // Single adder evaluation per cycle; carry-in is always zero.
    acc_add_core #(.WIDTH(WIDTH)) u_add (
        .i_a    (r_acc),
        .i_b    (i_in_data),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

`ifdef SUM_ACC_SATURATE_EN
    // Once clamped, further adds of nonzero data carry again and re-clamp,
    // and adds of zero leave all-ones unchanged, so the clamp is sticky.
    localparam logic [WIDTH-1:0] SAT_VAL = WIDTH'(sat_ones());
    assign w_acc_next = w_cout ? SAT_VAL : w_sum;
`else
    assign w_acc_next = w_sum;
`endif

    assign w_beat    = i_in_valid && (r_state == ST_ACCUM);
    assign o_out_sum = r_acc;
    assign o_out_overflow = r_ovf;

    // Next-state and handshake outputs derived from the current state.
    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start)
                    w_next = (i_burst_len == '0) ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (i_in_valid && (r_cnt == CNT_W'(1)))
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                o_out_valid = 1'b1;
                o_busy      = 1'b1;
                if (i_out_ready)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register plus accumulator, sticky overflow and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && i_start) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
                r_cnt <= i_burst_len;
            end else if (w_beat) begin
                r_acc <= w_acc_next;
                r_ovf <= r_ovf | w_cout;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator with a queue-based result scoreboard.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  burst_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];   // {overflow, sum}

    always #5 clk = ~clk;

    sum_accumulator dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (start),
        .i_burst_len    (burst_len),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_data      (in_data),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_sum      (out_sum),
        .o_out_overflow (out_overflow),
        .o_busy         (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [7:0] len);
        start     = 1'b1;
        burst_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: every result handshake pops and checks one expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got sum 0x%0h with empty queue", out_sum);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("sb_sum", 64'(out_sum), 64'(e[31:0]));
                chk("sb_ovf", 64'(out_overflow), 64'(e[32]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; burst_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(out_sum), 64'd0);
        chk("rst_ovf", 64'(out_overflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();

        // Basic burst 5+7+9 with in_valid held high.
        start_burst(8'd3);
        @(negedge clk);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        beat(32'd5);
        beat(32'd7);
        @(negedge clk);
        chk("t1_not_done_early", 64'(out_valid), 64'd0);
        exp_q.push_back({1'b0, 32'd21});
        beat(32'd9);
        @(negedge clk);
        chk("t1_latency", 64'(out_valid), 64'd1);
        tick();
        @(negedge clk);
        chk("t1_back_idle_valid", 64'(out_valid), 64'd0);
        chk("t1_back_idle_busy", 64'(busy), 64'd0);

        // Wraparound with sticky overflow.
        start_burst(8'd2);
        beat(32'hFFFF_FFFF);
`ifdef SUM_ACC_SATURATE_EN
        exp_q.push_back({1'b1, 32'hFFFF_FFFF});
`else
        exp_q.push_back({1'b1, 32'h0000_0001});
`endif
        beat(32'h2);
        tick();

        // Zero-length burst goes straight to DONE.
        exp_q.push_back({1'b0, 32'd0});
        start_burst(8'd0);
        @(negedge clk);
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        tick();

        // Gapped beats and backpressure in DONE.
        out_ready = 1'b0;
        start_burst(8'd4);
        beat(32'd1);
        tick(); tick();
        beat(32'd2);
        beat(32'd3);
        tick();
        exp_q.push_back({1'b0, 32'd10});
        beat(32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_sum", 64'(out_sum), 64'd10);
            tick();
        end
        out_ready = 1'b1;
        tick();

        // Reset mid-burst discards partial sum.
        start_burst(8'd4);
        beat(32'd3);
        beat(32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_sum", 64'(out_sum), 64'd0);
        chk("t5_ovf", 64'(out_overflow), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        start_burst(8'd2);
        beat(32'd1);
        exp_q.push_back({1'b0, 32'd11});
        beat(32'd10);
        tick();

        // start pulsed during ACCUM and DONE must be ignored.
        out_ready = 1'b0;
        start_burst(8'd2);
        start = 1'b1; burst_len = 8'd0;
        beat(32'd100);
        start = 1'b0;
        @(negedge clk);
        chk("t6_still_accum", 64'(in_ready), 64'd1);
        chk("t6_not_done", 64'(out_valid), 64'd0);
        exp_q.push_back({1'b0, 32'd300});
        beat(32'd200);
        start = 1'b1; burst_len = 8'd5;
        tick(); tick();
        start = 1'b0;
        @(negedge clk);
        chk("t6_done_valid", 64'(out_valid), 64'd1);
        chk("t6_done_sum", 64'(out_sum), 64'd300);
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_idle_busy", 64'(busy), 64'd0);

        tick(); tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
